// File: rtl/vdp_sprite_render_if.sv
// Purpose: memory-side bundle of the sprite line renderer (hit list, attributes, VRAM, line buffer).
// Latency: n/a (wires only); hit-list and attribute data are expected one cycle after their address.
// Backpressure: VRAM reads are held until vram_data_valid; the line buffer always accepts writes.
// Ports: master = renderer side, slave = memory/environment side.
interface vdp_sprite_render_if;
   logic        restart;
   logic [13:0] vram_base_address;
   logic [13:0] vram_read_address;
   logic [31:0] vram_read_data;
   logic        vram_data_valid;
   logic [7:0]  sprite_meta_address;
   logic [9:0]  character;
   logic [3:0]  palette;
   logic [1:0]  pixel_priority;
   logic [9:0]  target_x;
   logic        flip_x;
   logic [7:0]  hit_list_read_address;
   logic [7:0]  sprite_id;
   logic [3:0]  line_offset;
   logic        width_select;
   logic        hit_list_ended;
   logic [9:0]  line_buffer_write_address;
   logic [12:0] line_buffer_write_data;
   logic        line_buffer_write_en;

   modport master (
      input  restart, vram_base_address, vram_read_data, vram_data_valid,
             character, palette, pixel_priority, target_x, flip_x,
             sprite_id, line_offset, width_select, hit_list_ended,
      output vram_read_address, sprite_meta_address, hit_list_read_address,
             line_buffer_write_address, line_buffer_write_data, line_buffer_write_en
   );

   modport slave (
      output restart, vram_base_address, vram_read_data, vram_data_valid,
             character, palette, pixel_priority, target_x, flip_x,
             sprite_id, line_offset, width_select, hit_list_ended,
      input  vram_read_address, sprite_meta_address, hit_list_read_address,
             line_buffer_write_address, line_buffer_write_data, line_buffer_write_en
   );
endinterface

// File: rtl/vdp_sprite_render.sv
// Purpose: walks the per-line sprite hit list, fetches one VRAM row per 8-px half and blits it to the line buffer.
// Latency: 3 cycles from restart to the first VRAM request; 8 cycles of pixels per fetched word.
// Backpressure: stalls in VRAM_FETCH until vram_data_valid; line-buffer writes are never stalled.
// Ports: clk, reset (sync, active-high); bus = vdp_sprite_render_if.master carrying restart and all memory buses.
module vdp_sprite_render (
   input  logic                       clk,
   input  logic                       reset,
   vdp_sprite_render_if.master        bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_HIT_READ, S_HIT_WAIT, S_META_WAIT, S_VRAM_FETCH, S_BLIT
   } state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_index;
   logic [7:0]  r_sprite_id;
   logic [3:0]  r_line_offset;
   logic        r_width;
   logic [9:0]  r_char;
   logic [3:0]  r_pal;
   logic [1:0]  r_prio;
   logic [9:0]  r_tx;
   logic        r_flip;
   logic        r_half;
   logic [2:0]  r_col;
   logic [31:0] r_data;

   logic [9:0]  w_tile;
   logic [13:0] w_vram_addr;
   logic [2:0]  w_nib;
   logic [3:0]  w_pixel;
   logic [8:0]  w_index_inc;
   logic [13:0] w_vram_out;
   logic [7:0]  w_meta_addr;
   logic [9:0]  w_lb_addr;
   logic [12:0] w_lb_data;
   logic        w_lb_we;

   // Bottom half of a 16-row sprite lives 16 tiles further on; the right half of a
   // 16-px sprite is the next tile, swapped when the sprite is mirrored.
   assign w_tile      = r_char + (r_line_offset[3] ? 10'd16 : 10'd0)
                      + ((r_width && (r_half ^ r_flip)) ? 10'd1 : 10'd0);
   assign w_vram_addr = bus.vram_base_address + {1'b0, w_tile, 3'b000}
                      + {11'd0, r_line_offset[2:0]};
   assign w_nib       = r_flip ? (3'd7 - r_col) : r_col;
   assign w_pixel     = r_data[{w_nib, 2'b00} +: 4];
   // Bit 8 flags that all 256 entries have been processed.
   assign w_index_inc = {1'b0, r_index} + 9'd1;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_vram_out  = 14'd0;
      w_meta_addr = r_sprite_id;
      w_lb_addr   = 10'd0;
      w_lb_data   = 13'd0;
      w_lb_we     = 1'b0;

      if (bus.restart) begin
         w_next = S_HIT_READ;
      end else begin
         case (r_state)
            S_HIT_READ:   w_next = S_HIT_WAIT;
            S_HIT_WAIT:   w_next = bus.hit_list_ended ? S_IDLE : S_META_WAIT;
            S_META_WAIT:  w_next = S_VRAM_FETCH;
            S_VRAM_FETCH: if (bus.vram_data_valid) w_next = S_BLIT;
            S_BLIT: begin
               if (r_col == 3'd7) begin
                  if (r_width && !r_half) w_next = S_VRAM_FETCH;
                  else if (w_index_inc[8]) w_next = S_IDLE;
                  else                     w_next = S_HIT_READ;
               end
            end
            default:      w_next = r_state;
         endcase
      end

      // Outputs follow the current state only; a restart takes effect on the next cycle.
      case (r_state)
         S_HIT_WAIT:   w_meta_addr = bus.sprite_id;
         S_VRAM_FETCH: w_vram_out  = w_vram_addr;
         S_BLIT: begin
            w_lb_addr = r_tx + {6'd0, r_half, r_col};
            w_lb_data = {3'b000, r_prio, r_pal, w_pixel};
            w_lb_we   = (w_pixel != 4'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_index       <= 8'd0;
         r_sprite_id   <= 8'd0;
         r_line_offset <= 4'd0;
         r_width       <= 1'b0;
         r_char        <= 10'd0;
         r_pal         <= 4'd0;
         r_prio        <= 2'd0;
         r_tx          <= 10'd0;
         r_flip        <= 1'b0;
         r_half        <= 1'b0;
         r_col         <= 3'd0;
         r_data        <= 32'd0;
      end else if (bus.restart) begin
         r_index <= 8'd0;
         r_half  <= 1'b0;
         r_col   <= 3'd0;
      end else begin
         case (r_state)
            S_HIT_WAIT: begin
               if (!bus.hit_list_ended) begin
                  r_sprite_id   <= bus.sprite_id;
                  r_line_offset <= bus.line_offset;
                  r_width       <= bus.width_select;
               end
            end
            S_META_WAIT: begin
               r_char <= bus.character;
               r_pal  <= bus.palette;
               r_prio <= bus.pixel_priority;
               r_tx   <= bus.target_x;
               r_flip <= bus.flip_x;
               r_half <= 1'b0;
            end
            S_VRAM_FETCH: begin
               if (bus.vram_data_valid) begin
                  r_data <= bus.vram_read_data;
                  r_col  <= 3'd0;
               end
            end
            S_BLIT: begin
               r_col <= r_col + 3'd1;
               if (r_col == 3'd7) begin
                  if (r_width && !r_half) r_half  <= 1'b1;
                  else                    r_index <= w_index_inc[7:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.vram_read_address         = w_vram_out;
   assign bus.sprite_meta_address       = w_meta_addr;
   assign bus.hit_list_read_address     = r_index;
   assign bus.line_buffer_write_address = w_lb_addr;
   assign bus.line_buffer_write_data    = w_lb_data;
   assign bus.line_buffer_write_en      = w_lb_we;

endmodule

// File: tb/tb_vdp_sprite_render.sv
`timescale 1ns/1ps
module tb_vdp_sprite_render;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vdp_sprite_render_if bus();
   vdp_sprite_render dut (.clk(clk), .reset(reset), .bus(bus));

   // Hit-list and attribute tables; the address is held across the read, so a
   // combinational lookup is valid in the cycle after the address is issued.
   logic [7:0] hl_id   [256];
   logic [3:0] hl_lo   [256];
   logic       hl_w    [256];
   logic       hl_end  [256];
   logic [9:0] at_char [256];
   logic [3:0] at_pal  [256];
   logic [1:0] at_prio [256];
   logic [9:0] at_x    [256];
   logic       at_flip [256];

   assign bus.sprite_id      = hl_id [bus.hit_list_read_address];
   assign bus.line_offset    = hl_lo [bus.hit_list_read_address];
   assign bus.width_select   = hl_w  [bus.hit_list_read_address];
   assign bus.hit_list_ended = hl_end[bus.hit_list_read_address];
   assign bus.character      = at_char[bus.sprite_meta_address];
   assign bus.palette        = at_pal [bus.sprite_meta_address];
   assign bus.pixel_priority = at_prio[bus.sprite_meta_address];
   assign bus.target_x       = at_x   [bus.sprite_meta_address];
   assign bus.flip_x         = at_flip[bus.sprite_meta_address];

   int errors = 0;
   int checks = 0;

   logic [9:0]  wr_addr [$];
   logic [12:0] wr_dat  [$];
   logic [12:0] lb      [1024];

   always @(negedge clk) begin
      if (bus.line_buffer_write_en === 1'b1) begin
         wr_addr.push_back(bus.line_buffer_write_address);
         wr_dat.push_back(bus.line_buffer_write_data);
         lb[bus.line_buffer_write_address] = bus.line_buffer_write_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 256; i++) begin
         hl_id[i] = 8'd0; hl_lo[i] = 4'd0; hl_w[i] = 1'b0; hl_end[i] = 1'b1;
         at_char[i] = 10'd0; at_pal[i] = 4'd0; at_prio[i] = 2'd0;
         at_x[i] = 10'd0; at_flip[i] = 1'b0;
      end
   endtask

   task automatic clear_wr();
      wr_addr.delete();
      wr_dat.delete();
      for (int i = 0; i < 1024; i++) lb[i] = 13'd0;
   endtask

   task automatic set_entry(input int idx, input logic [7:0] id, input logic [3:0] lo,
                            input logic w, input logic e);
      hl_id[idx] = id; hl_lo[idx] = lo; hl_w[idx] = w; hl_end[idx] = e;
   endtask

   task automatic set_sprite(input int id, input logic [9:0] ch, input logic [3:0] pal,
                             input logic [1:0] pr, input logic [9:0] x, input logic fl);
      at_char[id] = ch; at_pal[id] = pal; at_prio[id] = pr; at_x[id] = x; at_flip[id] = fl;
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
   endtask

   // Waits (bounded) for a VRAM request and returns the requested address.
   task automatic wait_fetch(output logic [13:0] addr, output bit ok);
      ok = 1'b0;
      addr = 14'd0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.vram_read_address != 14'd0) begin
            ok = 1'b1;
            addr = bus.vram_read_address;
         end
      end
   endtask

   // Answers the pending request at the current negedge for exactly one cycle.
   task automatic give_data(input logic [31:0] d);
      bus.vram_data_valid = 1'b1;
      bus.vram_read_data  = d;
      @(negedge clk);
      bus.vram_data_valid = 1'b0;
      bus.vram_read_data  = 32'd0;
   endtask

   task automatic test_reset();
      logic quiet;
      reset = 1'b1;
      tick(2);
      checks++; if (bus.vram_read_address !== 14'd0) begin errors++; $display("FAIL reset_vram_addr got=%h exp=0", bus.vram_read_address); end
      checks++; if (bus.sprite_meta_address !== 8'd0) begin errors++; $display("FAIL reset_meta_addr got=%h exp=0", bus.sprite_meta_address); end
      checks++; if (bus.hit_list_read_address !== 8'd0) begin errors++; $display("FAIL reset_hl_addr got=%h exp=0", bus.hit_list_read_address); end
      checks++; if (bus.line_buffer_write_address !== 10'd0) begin errors++; $display("FAIL reset_lb_addr got=%h exp=0", bus.line_buffer_write_address); end
      checks++; if (bus.line_buffer_write_data !== 13'd0) begin errors++; $display("FAIL reset_lb_data got=%h exp=0", bus.line_buffer_write_data); end
      checks++; if (bus.line_buffer_write_en !== 1'b0) begin errors++; $display("FAIL reset_lb_en got=%b exp=0", bus.line_buffer_write_en); end

      // Reset beats a simultaneous restart: the valid entry 0 must not be rendered.
      set_entry(0, 8'd3, 4'd2, 1'b0, 1'b0);
      set_sprite(3, 10'd5, 4'd7, 2'd2, 10'd100, 1'b0);
      clear_wr();
      bus.restart = 1'b1;
      tick(1);
      reset = 1'b0;
      bus.restart = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.vram_read_address !== 14'd0 || bus.line_buffer_write_en !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL reset_over_restart got=active exp=idle"); end
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL reset_no_writes got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_terminator();
      logic quiet;
      clear_tables();
      clear_wr();
      bus.vram_data_valid = 1'b1;
      bus.vram_read_data  = 32'hFFFF_FFFF;
      pulse_restart();
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.vram_read_address !== 14'd0) quiet = 1'b0;
      end
      bus.vram_data_valid = 1'b0;
      bus.vram_read_data  = 32'd0;
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL term_no_fetch got=fetch exp=none"); end
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL term_no_writes got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_8px();
      logic [13:0] a;
      bit ok;
      clear_tables();
      set_entry(0, 8'd3, 4'd2, 1'b0, 1'b0);
      set_sprite(3, 10'd5, 4'd7, 2'd2, 10'd100, 1'b0);
      clear_wr();
      pulse_restart();
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h102A) begin errors++; $display("FAIL px8_vram_addr got=%h ok=%0d exp=102a", a, ok); end
      tick(3);
      checks++; if (bus.vram_read_address !== 14'h102A) begin errors++; $display("FAIL px8_addr_hold got=%h exp=102a", bus.vram_read_address); end
      give_data(32'h8765_4321);
      tick(20);
      checks++; if (wr_addr.size() != 8) begin errors++; $display("FAIL px8_count got=%0d exp=8", wr_addr.size()); end
      if (wr_addr.size() == 8)
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_addr[i] !== 10'(100 + i) || wr_dat[i] !== 13'(13'h271 + i)) begin
               errors++; $display("FAIL px8_pixel%0d got=%0d/%h exp=%0d/%h", i, wr_addr[i], wr_dat[i], 100 + i, 13'h271 + i);
            end
         end
   endtask

   task automatic test_flip();
      logic [13:0] a;
      bit ok;
      set_sprite(3, 10'd5, 4'd7, 2'd2, 10'd100, 1'b1);
      clear_wr();
      pulse_restart();
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h102A) begin errors++; $display("FAIL flip_vram_addr got=%h ok=%0d exp=102a", a, ok); end
      give_data(32'h8765_4321);
      tick(20);
      checks++; if (wr_addr.size() != 8) begin errors++; $display("FAIL flip_count got=%0d exp=8", wr_addr.size()); end
      if (wr_addr.size() == 8)
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_addr[i] !== 10'(100 + i) || wr_dat[i] !== 13'(13'h278 - i)) begin
               errors++; $display("FAIL flip_pixel%0d got=%0d/%h exp=%0d/%h", i, wr_addr[i], wr_dat[i], 100 + i, 13'h278 - i);
            end
         end
   endtask

   task automatic test_transparent_wrap();
      logic [13:0] a;
      bit ok;
      set_sprite(3, 10'd5, 4'd7, 2'd2, 10'd1020, 1'b0);
      clear_wr();
      pulse_restart();
      wait_fetch(a, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_fetch got=timeout exp=request"); end
      give_data(32'h0000_3021);
      tick(20);
      checks++; if (wr_addr.size() != 3) begin errors++; $display("FAIL wrap_count got=%0d exp=3", wr_addr.size()); end
      if (wr_addr.size() == 3) begin
         checks++; if (wr_addr[0] !== 10'd1020 || wr_dat[0] !== 13'h271) begin errors++; $display("FAIL wrap_w0 got=%0d/%h exp=1020/271", wr_addr[0], wr_dat[0]); end
         checks++; if (wr_addr[1] !== 10'd1021 || wr_dat[1] !== 13'h272) begin errors++; $display("FAIL wrap_w1 got=%0d/%h exp=1021/272", wr_addr[1], wr_dat[1]); end
         checks++; if (wr_addr[2] !== 10'd1023 || wr_dat[2] !== 13'h273) begin errors++; $display("FAIL wrap_w2 got=%0d/%h exp=1023/273", wr_addr[2], wr_dat[2]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] a;
      bit ok;
      clear_tables();
      set_entry(0, 8'd10, 4'd0, 1'b0, 1'b0);
      set_entry(1, 8'd11, 4'd0, 1'b0, 1'b0);
      set_sprite(10, 10'd0, 4'd1, 2'd0, 10'd200, 1'b0);
      set_sprite(11, 10'd1, 4'd2, 2'd1, 10'd204, 1'b0);
      clear_wr();
      pulse_restart();
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h1000) begin errors++; $display("FAIL b2b_fetch0 got=%h ok=%0d exp=1000", a, ok); end
      give_data(32'h1111_1111);
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h1008) begin errors++; $display("FAIL b2b_fetch1 got=%h ok=%0d exp=1008", a, ok); end
      checks++; if (bus.hit_list_read_address !== 8'd1) begin errors++; $display("FAIL b2b_index got=%0d exp=1", bus.hit_list_read_address); end
      give_data(32'h2222_2222);
      tick(20);
      checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", wr_addr.size()); end
      checks++; if (lb[200] !== 13'h011) begin errors++; $display("FAIL b2b_x200 got=%h exp=011", lb[200]); end
      checks++; if (lb[203] !== 13'h011) begin errors++; $display("FAIL b2b_x203 got=%h exp=011", lb[203]); end
      checks++; if (lb[204] !== 13'h122) begin errors++; $display("FAIL b2b_overwrite_x204 got=%h exp=122", lb[204]); end
      checks++; if (lb[211] !== 13'h122) begin errors++; $display("FAIL b2b_x211 got=%h exp=122", lb[211]); end
   endtask

   task automatic test_16px_restart();
      logic [13:0] a;
      bit ok;
      clear_tables();
      set_entry(0, 8'd3, 4'd2, 1'b0, 1'b0);
      set_entry(1, 8'd20, 4'd9, 1'b1, 1'b0);
      set_sprite(3, 10'd5, 4'd7, 2'd2, 10'd100, 1'b0);
      set_sprite(20, 10'd5, 4'd7, 2'd2, 10'd300, 1'b0);
      clear_wr();
      pulse_restart();
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h102A) begin errors++; $display("FAIL p16_entry0 got=%h ok=%0d exp=102a", a, ok); end
      give_data(32'h8765_4321);
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h10A9) begin errors++; $display("FAIL p16_half0 got=%h ok=%0d exp=10a9", a, ok); end
      give_data(32'h8765_4321);
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h10B1) begin errors++; $display("FAIL p16_half1 got=%h ok=%0d exp=10b1", a, ok); end
      checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL p16_half0_count got=%0d exp=16", wr_addr.size()); end
      if (wr_addr.size() == 16) begin
         checks++; if (wr_addr[8] !== 10'd300 || wr_dat[8] !== 13'h271) begin errors++; $display("FAIL p16_x300 got=%0d/%h exp=300/271", wr_addr[8], wr_dat[8]); end
         checks++; if (wr_addr[15] !== 10'd307 || wr_dat[15] !== 13'h278) begin errors++; $display("FAIL p16_x307 got=%0d/%h exp=307/278", wr_addr[15], wr_dat[15]); end
      end
      give_data(32'hFEDC_BA98);
      checks++;
      if (bus.line_buffer_write_en !== 1'b1 || bus.line_buffer_write_address !== 10'd308 || bus.line_buffer_write_data !== 13'h278) begin
         errors++; $display("FAIL p16_x308 got=%b/%0d/%h exp=1/308/278", bus.line_buffer_write_en, bus.line_buffer_write_address, bus.line_buffer_write_data);
      end
      tick(2);
      checks++;
      if (bus.line_buffer_write_en !== 1'b1 || bus.line_buffer_write_address !== 10'd310 || bus.line_buffer_write_data !== 13'h27A) begin
         errors++; $display("FAIL p16_x310 got=%b/%0d/%h exp=1/310/27a", bus.line_buffer_write_en, bus.line_buffer_write_address, bus.line_buffer_write_data);
      end
      bus.restart = 1'b1;
      @(negedge clk);
      checks++; if (bus.line_buffer_write_en !== 1'b0) begin errors++; $display("FAIL restart_we_low got=%b exp=0", bus.line_buffer_write_en); end
      checks++; if (bus.hit_list_read_address !== 8'd0) begin errors++; $display("FAIL restart_index got=%0d exp=0", bus.hit_list_read_address); end
      bus.restart = 1'b0;
      wait_fetch(a, ok);
      checks++; if (!ok || a !== 14'h102A) begin errors++; $display("FAIL restart_refetch got=%h ok=%0d exp=102a", a, ok); end
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic test_wrap256();
      logic [13:0] a;
      bit ok;
      int n;
      logic quiet;
      clear_tables();
      for (int i = 0; i < 256; i++) set_entry(i, 8'd30, 4'd0, 1'b0, 1'b0);
      set_sprite(30, 10'd0, 4'd1, 2'd0, 10'd0, 1'b0);
      clear_wr();
      pulse_restart();
      n = 0;
      for (int i = 0; i < 256; i++) begin
         wait_fetch(a, ok);
         if (!ok) break;
         n++;
         give_data(32'h0000_0000);
      end
      checks++; if (n != 256) begin errors++; $display("FAIL w256_fetches got=%0d exp=256", n); end
      quiet = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.vram_read_address !== 14'd0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL w256_idle got=fetch exp=none"); end
      checks++; if (bus.hit_list_read_address !== 8'd0) begin errors++; $display("FAIL w256_index got=%0d exp=0", bus.hit_list_read_address); end
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL w256_transparent got=%0d exp=0", wr_addr.size()); end
   endtask

   initial begin
      reset = 1'b1;
      bus.restart = 1'b0;
      bus.vram_base_address = 14'h1000;
      bus.vram_read_data = 32'd0;
      bus.vram_data_valid = 1'b0;
      clear_tables();
      clear_wr();
      test_reset();
      test_terminator();
      test_8px();
      test_flip();
      test_transparent_wrap();
      test_back_to_back();
      test_16px_restart();
      test_wrap256();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vdp_sprite_render.md
VDP_SPRITE_RENDER -- requirements
Module: vdp_sprite_render

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port restart, input, 1 bit: start-of-line pulse; begins rendering from hit-list entry 0.
REQ-004 SHALL have port vram_base_address, input, 14 bits: sprite graphics base, in 32-bit words.
REQ-005 SHALL have port vram_read_address, output, 14 bits: VRAM word address requested.
REQ-006 SHALL have ports vram_read_data (input, 32 bits) and vram_data_valid (input, 1 bit): fetched word, qualified by valid.
REQ-007 SHALL have port sprite_meta_address, output, 8 bits: sprite ID presented to the attribute RAMs.
REQ-008 SHALL have attribute inputs, valid 1 cycle after sprite_meta_address: character 10 bits, palette 4 bits, pixel_priority 2 bits, target_x 10 bits, flip_x 1 bit.
REQ-009 SHALL have port hit_list_read_address, output, 8 bits: hit-list entry index.
REQ-010 SHALL have hit-list inputs, valid 1 cycle after hit_list_read_address: sprite_id 8 bits, line_offset 4 bits (already Y-flipped row 0-15), width_select 1 bit (1 = 16 px wide), hit_list_ended 1 bit (terminator).
REQ-011 SHALL have ports line_buffer_write_address (output, 10 bits), line_buffer_write_data (output, 13 bits) and line_buffer_write_en (output, 1 bit).

Function
REQ-012 SHALL implement states IDLE, HIT_READ, HIT_WAIT, META_WAIT, VRAM_FETCH, BLIT.
REQ-013 restart SHALL, from any state, zero the entry index, force line_buffer_write_en low next cycle and enter HIT_READ; restart wins over all other events.
REQ-014 HIT_READ: drive hit_list_read_address = index; next state HIT_WAIT.
REQ-015 HIT_WAIT: if hit_list_ended=1, go to IDLE; else latch sprite_id/line_offset/width_select, drive sprite_meta_address = sprite_id, go to META_WAIT.
REQ-016 META_WAIT: latch attributes; set half = 0; go to VRAM_FETCH.
REQ-017 Tile select: tile = character + (line_offset[3] ? 16 : 0) + (width_select ? (half XOR flip_x) : 0), 10-bit wrap.
REQ-018 VRAM address = vram_base_address + tile*8 + line_offset[2:0], modulo 2^14.
REQ-019 VRAM_FETCH: hold vram_read_address stable until a cycle with vram_data_valid=1; capture vram_read_data that cycle and go to BLIT; vram_data_valid outside VRAM_FETCH SHALL be ignored.
REQ-020 BLIT: one pixel per cycle, column c = 0..7; nibble index n = flip_x ? 7-c : c; pixel = data[4n+3:4n].
REQ-021 Write address = target_x + half*8 + c, modulo 1024 (wraps past 1023 to 0).
REQ-022 Write data = {3'b000, pixel_priority, palette, pixel}; line_buffer_write_en=1 only when pixel != 0 (index 0 transparent).
REQ-023 After c=7: if width_select=1 and half=0, set half=1 and return to VRAM_FETCH; otherwise increment index.
REQ-024 After the increment: if the index wrapped past 255 (256 entries done), go to IDLE; else go to HIT_READ.
REQ-025 Later hit-list entries SHALL overwrite earlier ones at the same X (no read-back of the line buffer).
REQ-026 IDLE: no writes, no VRAM requests; remain until restart.

Reset
REQ-027 reset SHALL force state IDLE, index 0, half 0, and every output to 0 (line_buffer_write_en=0) on the next clock edge.
REQ-028 reset SHALL take precedence over restart.

Verification
REQ-029 Reset: assert reset 2 cycles -> all outputs 0, write_en never rises until restart.
REQ-030 Terminator: restart, entry 0 hit_list_ended=1 -> no vram_data_valid consumed, zero line-buffer writes.
REQ-031 8-px sprite: base 0x1000, char 5, line_offset 2, x=100, palette 7, prio 2, data 0x87654321 -> vram_read_address 0x102A; writes x 100..107, data 0x271..0x278.
REQ-032 Same with flip_x=1 -> x=100 gets 0x278, x=107 gets 0x271.
REQ-033 Transparency/wrap: x=1020, data 0x00003021 -> writes only at 1020 (0x..1), 1021 (0x..2), 1023 (0x..3); 1022 and 0..3 skipped.
REQ-034 16-px sprite, char 5, line_offset 9, flip_x=0 -> fetches 0x1000+21*8+1 then 0x1000+22*8+1, pixels at x..x+15; restart during second BLIT -> write_en low next cycle, entry 0 re-read.
